// File: rtl/prog_sequencer_pkg.sv
// Shared types and default constants for the program run sequencer.
//   seq_state_t      : sequencer state encoding (IDLE, LAUNCH, RUN, REPORT)
//   DEF_START_CYC    : default number of cycles the core is held in init
//   DEF_CW           : default cycle-counter width
//   DEF_TIMEOUT_CYC  : default watchdog limit in RUN cycles
package definitions;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } seq_state_t;

    localparam int          DEF_START_CYC   = 2;
    localparam int          DEF_CW          = 16;
    localparam int unsigned DEF_TIMEOUT_CYC = 60000;

endpackage

// File: rtl/prog_sequencer_if.sv
// Host-side handshake bundle of the program run sequencer.
//   go, prog_id, ack : run request, program number, result acknowledge (host -> sequencer)
//   busy, done       : sequencer activity and result-valid flags
//   timeout          : run ended by watchdog (valid with done)
//   cycle_count      : halt-low RUN cycles of the last run (valid with done)
//   err              : one-cycle pulse on a request with an illegal program number
//   runs_done        : count of completed runs, wraps at 256
// master = host bench, slave = sequencer.
interface prog_sequencer_if #(
    parameter int CW = 16
);
    logic          go;
    logic [1:0]    prog_id;
    logic          ack;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycle_count;
    logic          err;
    logic [7:0]    runs_done;

    modport master (
        output go, prog_id, ack,
        input  busy, done, timeout, cycle_count, err, runs_done
    );

    modport slave (
        input  go, prog_id, ack,
        output busy, done, timeout, cycle_count, err, runs_done
    );
endinterface

// File: rtl/prog_sequencer.sv
// Run controller for the 9-bit core: holds the core in init while idle,
// launches a selected program, measures its run length until halt or
// watchdog, and reports the result to the host with a done/ack handshake.
// Ports:
//   CLK        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   host       : host handshake bundle (slave side), see prog_sequencer_if
//   dut_halt   : halt flag from the core
//   dut_start  : start/init drive to the core
//   prog_sel   : registered program select to the core
//
// state  | meaning
// IDLE   | core held in init, waiting for go
// LAUNCH | core held in init for START_CYC cycles, halt ignored
// RUN    | core released, counting halt-low cycles
// REPORT | result presented with done, core frozen, waiting for ack
module prog_sequencer
    import definitions::*;
#(
    parameter int          NPROG       = 3,
    parameter int          START_CYC   = DEF_START_CYC,
    parameter int          CW          = DEF_CW,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                    CLK,
    input  logic                    reset_n,
    prog_sequencer_if.slave         host,
    input  logic                    dut_halt,
    output logic                    dut_start,
    output logic [1:0]              prog_sel
);

    localparam int SW = $clog2(START_CYC + 1);
    localparam logic [SW-1:0] START_LAST = SW'(START_CYC - 1);
    // The watchdog fires on the edge that would bring the count to the limit,
    // so cycle_count ends exactly at TIMEOUT_CYC.
    localparam logic [CW-1:0] WDOG_LAST  = CW'(TIMEOUT_CYC - 1);

    seq_state_t    state;
    seq_state_t    state_next;
    logic [SW-1:0] start_cnt;
    logic [CW-1:0] cycle_count;
    logic          timeout_q;
    logic          err_q;
    logic [7:0]    runs_done;

    logic          go_ok;
    logic          go_bad;
    logic          run_wdog;
    logic          report_ack;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        go_ok      = 1'b0;
        go_bad     = 1'b0;
        run_wdog   = 1'b0;
        report_ack = 1'b0;
        case (state)
            IDLE: begin
                if (host.go) begin
                    if (int'(host.prog_id) < NPROG) begin
                        go_ok      = 1'b1;
                        state_next = LAUNCH;
                    end else begin
                        go_bad = 1'b1;
                    end
                end
            end
            LAUNCH: begin
                if (start_cnt == START_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // Halt has priority over a coincident watchdog expiry.
                if (dut_halt) begin
                    state_next = REPORT;
                end else if (cycle_count == WDOG_LAST) begin
                    run_wdog   = 1'b1;
                    state_next = REPORT;
                end
            end
            REPORT: begin
                if (host.ack) begin
                    report_ack = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            start_cnt   <= '0;
            cycle_count <= '0;
            timeout_q   <= 1'b0;
            err_q       <= 1'b0;
            runs_done   <= '0;
            prog_sel    <= '0;
        end else begin
            err_q <= go_bad;
            if (go_ok) begin
                prog_sel    <= host.prog_id;
                start_cnt   <= '0;
                cycle_count <= '0;
                timeout_q   <= 1'b0;
            end
            if (state == LAUNCH) begin
                start_cnt <= start_cnt + SW'(1);
            end
            if (state == RUN && !dut_halt) begin
                cycle_count <= cycle_count + CW'(1);
            end
            if (run_wdog) begin
                timeout_q <= 1'b1;
            end
            if (report_ack) begin
                runs_done <= runs_done + 8'd1;
            end
        end
    end

    // Outputs decode registered state only.
    assign dut_start        = (state == IDLE) || (state == LAUNCH);
    assign host.busy        = (state != IDLE);
    assign host.done        = (state == REPORT);
    assign host.timeout     = timeout_q;
    assign host.cycle_count = cycle_count;
    assign host.err         = err_q;
    assign host.runs_done   = runs_done;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed scenarios plus randomized
// runs, each compared against a run-level model of the expected result.
module tb_prog_sequencer;
    import definitions::*;

    localparam int NPROG     = 3;
    localparam int START_CYC = 2;
    localparam int CW        = 16;
    localparam int TOUT      = 100;

    logic       CLK = 1'b0;
    logic       reset_n = 1'b1;
    logic       dut_halt = 1'b0;
    logic       dut_start;
    logic [1:0] prog_sel;

    prog_sequencer_if #(.CW(CW)) host_if();

    prog_sequencer #(
        .NPROG      (NPROG),
        .START_CYC  (START_CYC),
        .CW         (CW),
        .TIMEOUT_CYC(TOUT)
    ) dut (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .host     (host_if),
        .dut_halt (dut_halt),
        .dut_start(dut_start),
        .prog_sel (prog_sel)
    );

    always #5 CLK = ~CLK;

    int n_vec    = 0;
    int n_miss   = 0;
    int exp_runs = 0;
    int exp_sel  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_start"}, 32'(dut_start), 1);
        check_val({tag, "_busy"}, 32'(host_if.busy), 0);
        check_val({tag, "_done"}, 32'(host_if.done), 0);
        check_val({tag, "_runs"}, 32'(host_if.runs_done), exp_runs);
        check_val({tag, "_sel"}, 32'(prog_sel), exp_sel);
    endtask

    // h = RUN cycle (1-based) on which halt rises; 0 = never.
    task automatic run_one(input int pid, input int h, input bit stale, input bit noise);
        bit exp_to;
        int exp_cnt;
        int j_end;
        int hold;
        exp_to  = (h == 0) || (h - 1 >= TOUT);
        exp_cnt = exp_to ? TOUT : h - 1;
        j_end   = exp_to ? TOUT : h;

        host_if.go      = 1'b1;
        host_if.prog_id = 2'(pid);
        dut_halt        = stale;
        tick();
        host_if.go = 1'b0;
        exp_sel    = pid;
        check_val("launch_busy", 32'(host_if.busy), 1);
        check_val("launch_start", 32'(dut_start), 1);
        for (int i = 1; i < START_CYC; i++) begin
            tick();
            check_val("launch_hold", 32'(dut_start), 1);
        end
        tick();
        check_val("run_start", 32'(dut_start), 0);
        check_val("run_sel", 32'(prog_sel), exp_sel);
        for (int j = 1; j <= j_end; j++) begin
            dut_halt = (j == h);
            if (noise) begin
                host_if.go      = ($urandom_range(0, 3) == 0);
                host_if.prog_id = 2'($urandom_range(0, 3));
                host_if.ack     = ($urandom_range(0, 3) == 0);
            end
            if (j == j_end) check_val("run_not_done", 32'(host_if.done), 0);
            tick();
            host_if.go  = 1'b0;
            host_if.ack = 1'b0;
        end
        check_val("rep_done", 32'(host_if.done), 1);
        check_val("rep_busy", 32'(host_if.busy), 1);
        check_val("rep_start", 32'(dut_start), 0);
        check_val("rep_count", 32'(host_if.cycle_count), exp_cnt);
        check_val("rep_timeout", 32'(host_if.timeout), 32'(exp_to));
        check_val("rep_sel", 32'(prog_sel), exp_sel);
        check_val("rep_err", 32'(host_if.err), 0);
        hold = $urandom_range(0, 3);
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                host_if.go      = 1'b1;
                host_if.prog_id = 2'($urandom_range(0, 3));
            end
            tick();
            host_if.go = 1'b0;
            check_val("hold_done", 32'(host_if.done), 1);
            check_val("hold_count", 32'(host_if.cycle_count), exp_cnt);
            check_val("hold_sel", 32'(prog_sel), exp_sel);
        end
        host_if.ack = 1'b1;
        tick();
        host_if.ack = 1'b0;
        exp_runs = (exp_runs + 1) % 256;
        check_idle("ack");
    endtask

    task automatic illegal_go();
        host_if.go      = 1'b1;
        host_if.prog_id = 2'd3;
        tick();
        host_if.go = 1'b0;
        check_val("ill_err", 32'(host_if.err), 1);
        check_val("ill_busy", 32'(host_if.busy), 0);
        check_val("ill_sel", 32'(prog_sel), exp_sel);
        tick();
        check_val("ill_err_pulse", 32'(host_if.err), 0);
        check_idle("ill_idle");
    endtask

    task automatic async_reset(input string tag);
        #2 reset_n = 1'b0;
        #1;
        exp_runs = 0;
        exp_sel  = 0;
        check_val({tag, "_start"}, 32'(dut_start), 1);
        check_val({tag, "_busy"}, 32'(host_if.busy), 0);
        check_val({tag, "_done"}, 32'(host_if.done), 0);
        check_val({tag, "_timeout"}, 32'(host_if.timeout), 0);
        check_val({tag, "_err"}, 32'(host_if.err), 0);
        check_val({tag, "_count"}, 32'(host_if.cycle_count), 0);
        check_val({tag, "_runs"}, 32'(host_if.runs_done), 0);
        check_val({tag, "_sel"}, 32'(prog_sel), 0);
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        host_if.go      = 1'b0;
        host_if.prog_id = 2'd0;
        host_if.ack     = 1'b0;
        dut_halt        = 1'b0;

        async_reset("por");
        check_idle("por_idle");

        illegal_go();

        // Abort mid-run: reset during RUN, no report, no run counted.
        host_if.go      = 1'b1;
        host_if.prog_id = 2'd2;
        tick();
        host_if.go = 1'b0;
        for (int i = 0; i < START_CYC + 4; i++) tick();
        check_val("abort_busy_before", 32'(host_if.busy), 1);
        async_reset("abort");
        check_idle("abort_idle");

        run_one(1, 25, 1'b0, 1'b0);
        illegal_go();

        // ack while idle is not counted.
        host_if.ack = 1'b1;
        tick();
        host_if.ack = 1'b0;
        tick();
        check_idle("idle_ack");

        run_one(0, 0, 1'b0, 1'b0);
        run_one(2, TOUT, 1'b0, 1'b0);
        run_one(1, TOUT + 1, 1'b0, 1'b0);
        run_one(0, 1, 1'b0, 1'b0);
        run_one(2, 6, 1'b1, 1'b1);

        for (int r = 0; r < 20; r++) begin
            int h;
            if ($urandom_range(0, 9) == 0) h = 0;
            else if ($urandom_range(0, 4) == 0) h = $urandom_range(TOUT - 2, TOUT + 2);
            else h = $urandom_range(1, 40);
            run_one($urandom_range(0, NPROG - 1), h, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        async_reset("wrap_reset");
        for (int r = 0; r < 256; r++) begin
            run_one($urandom_range(0, NPROG - 1), 1, 1'b0, 1'b0);
        end
        check_val("wrap_runs", 32'(host_if.runs_done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Run controller that sequences the 9-bit core through its test programs. It holds the core in init (`start` high) while idle and selects which program the core runs. It releases init on request, then measures the run length in cycles until the core raises `halt` or a watchdog expires. It reports the result with a done/ack handshake to the host bench. It sits above the processor top level, driving its `start` input and observing its `halt` output.

## Interface
Parameters:
- NPROG, 3: number of selectable programs; legal `prog_id` values are 0..NPROG-1.
- START_CYC, 2: cycles `dut_start` is held high in LAUNCH; minimum 1.
- CW, 16: width of the cycle counter.
- TIMEOUT_CYC, 16'd60000: watchdog limit in RUN cycles; must be below 2^CW.

Ports:
- CLK  in  1  clock, posedge.
- reset_n  in  1  asynchronous, active-low reset.
- go  in  1  run request; sampled only in IDLE.
- prog_id  in  2  program to run; sampled together with `go`.
- ack  in  1  host acknowledges the result; sampled only in REPORT.
- dut_halt  in  1  `halt` from the core.
- dut_start  out  1  drives the core's `start`/init input.
- prog_sel  out  2  registered program select to the core/InstROM base.
- busy  out  1  high in every state except IDLE.
- done  out  1  result valid; high only in REPORT.
- timeout  out  1  set when the run ended by watchdog; valid while `done` is high.
- cycle_count  out  CW  halt-low RUN cycles of the last run; valid while `done` is high.
- err  out  1  one-cycle pulse when `go` arrives with an illegal `prog_id`.
- runs_done  out  8  count of completed runs; wraps from 255 to 0.

## Operation
- State encoding is `seq_state_t` with four states: IDLE, LAUNCH, RUN, REPORT.
- IDLE:
  - `dut_start`=1 and `busy`=0.
  - `go`=1 with `prog_id`<NPROG: latch `prog_sel`<=`prog_id`, clear the start counter and `cycle_count`, clear `timeout`, go to LAUNCH.
  - `go`=1 with `prog_id`>=NPROG: pulse `err` for one cycle and stay in IDLE.
- LAUNCH:
  - `dut_start`=1 for exactly START_CYC cycles, then go to RUN.
  - `dut_halt` is ignored in this state, because a stale halt from the previous run is possible.
- RUN:
  - `dut_start`=0.
  - Each cycle with `dut_halt`=0: `cycle_count` += 1.
  - `dut_halt`=1: go to REPORT with `timeout`=0; `cycle_count` is not incremented that cycle.
  - If `cycle_count` reaches TIMEOUT_CYC with `dut_halt`=0: go to REPORT with `timeout`=1 and `cycle_count` frozen at TIMEOUT_CYC.
  - If halt and the limit coincide in the same cycle, halt wins (`timeout`=0).
- REPORT:
  - `done`=1 and `dut_start`=0, so core state stays inspectable.
  - `cycle_count`, `timeout` and `prog_sel` are held stable.
  - `ack`=1: `runs_done` += 1 and go to IDLE.
  - `go` is ignored here.
- `go` or `ack` outside its sampling state has no effect and is not queued.
- `prog_sel` changes only on an accepted `go`.

## Timing
- Reset (reset_n=0, asynchronous):
  - state=IDLE, `dut_start`=1, `prog_sel`=0, `cycle_count`=0, `runs_done`=0.
  - `busy`, `done`, `timeout` and `err` are 0.
- Reset asserted mid-run aborts immediately. There is no report and `runs_done` is not incremented.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Accepted `go` at edge k: `busy` goes high after edge k. `dut_start` stays high through LAUNCH and falls after edge k+START_CYC.
- `dut_halt` sampled high at edge n in RUN: `done` goes high after edge n.
- `ack` sampled at edge m: `done` and `busy` go low after edge m. A new `go` is accepted from edge m+1.
- Minimum go-to-done time: START_CYC+1 cycles, reached when halt is high on the first RUN cycle, giving `cycle_count`=0.

## Structure
- Package `definitions`:
  - `typedef enum logic[1:0] seq_state_t` {IDLE, LAUNCH, RUN, REPORT}.
  - Default constants for START_CYC and TIMEOUT_CYC.
- Single module `prog_sequencer` containing:
  - the state register,
  - the start counter (width $clog2(START_CYC+1)),
  - the cycle counter,
  - the runs counter.
- No sub-module is required.

## Test plan
- Reset then idle: assert reset_n=0 mid-cycle -> `dut_start`=1 and all other outputs 0 immediately, without waiting for a clock edge.
- Normal run: go with prog_id=1; dut_halt rises on the 25th RUN cycle -> `dut_start` low for 24 cycles before halt, `prog_sel`=1, `done`=1, `cycle_count`=24, `timeout`=0; ack -> `runs_done`=1, return to IDLE.
- Watchdog: TIMEOUT_CYC=100, dut_halt held 0 -> `done`=1 with `cycle_count`=100, `timeout`=1.
- Illegal program: go with prog_id=3 (NPROG=3) -> single-cycle `err`, `busy` stays 0, `prog_sel` unchanged.
- Stale halt and ignored inputs: dut_halt=1 throughout LAUNCH, dropped in the first RUN cycle, re-raised after 5 cycles -> `cycle_count`=5. go pulses during RUN and REPORT -> no effect. ack during RUN -> no effect.
- Abort and wrap: reset during RUN -> IDLE with `runs_done` unchanged. Then 256 back-to-back completed runs -> `runs_done` wraps to 0.
